rom_boot_loader: RTL and testbench

//  Boot-time copy controller between the program ROM and the shared RAM.
//  - Out of reset, copies ROM_WORDS words from ROM 0.. into RAM RAM_BASE.., holding the F100-L core in reset.
//  - Then hands the RAM port to the core as a pass-through mux.
//  - A reload request re-runs the copy at any time, so a new image can be restarted without power cycling.

---
 rtl/rom_boot_loader_pkg.sv | 15 +
 rtl/rom_boot_loader_if.sv | 24 ++
 rtl/rom_boot_loader.sv | 93 +++++++++
 tb/tb_rom_boot_loader.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rom_boot_loader_pkg.sv
// Shared types and defaults for the ROM-to-RAM boot loader.
package rom_boot_loader_pkg;

  typedef enum logic [1:0] {
    STATE_FETCH = 2'd0,
    STATE_WRITE = 2'd1,
    STATE_DONE  = 2'd2
  } state_t;

  localparam int unsigned DEF_ADDR_WIDTH = 10;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_ROM_WORDS  = 8;
  localparam int unsigned DEF_RAM_BASE   = 0;

endpackage

// File: rtl/rom_boot_loader_if.sv
// ROM read port, RAM write port and core-side RAM request, bundled for the loader.
interface rom_boot_loader_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] rom_address;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_data_out;
  logic                  ram_write_enable;
  logic [ADDR_WIDTH-1:0] cpu_address;
  logic [DATA_WIDTH-1:0] cpu_data_out;
  logic                  cpu_write_enable;

  modport master (
    output rom_address, ram_address, ram_data_out, ram_write_enable,
    input  rom_data, cpu_address, cpu_data_out, cpu_write_enable
  );

  modport slave (
    input  rom_address, ram_address, ram_data_out, ram_write_enable,
    output rom_data, cpu_address, cpu_data_out, cpu_write_enable
  );
endinterface

// File: rtl/rom_boot_loader.sv
// Copies ROM_WORDS words from ROM into RAM at RAM_BASE while holding the core in
// reset, then hands the RAM port to the core. A reload pulse restarts the copy.
module rom_boot_loader
  import rom_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ROM_WORDS  = DEF_ROM_WORDS,
  parameter int unsigned RAM_BASE   = DEF_RAM_BASE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reload,
  rom_boot_loader_if.master     bus,
  output logic                  cpu_reset,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] copy_index
);

  if (64'(ROM_WORDS) > (64'd1 << ADDR_WIDTH)) begin : g_rom_words_too_large
    $error("rom_boot_loader: ROM_WORDS exceeds the 2^ADDR_WIDTH address space");
  end

  localparam state_t                START = (ROM_WORDS == 0) ? STATE_DONE : STATE_FETCH;
  localparam logic [ADDR_WIDTH-1:0] LAST  = (ROM_WORDS == 0) ? '0 : ADDR_WIDTH'(ROM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(RAM_BASE);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] latch_q, latch_d;
  logic                  done_q, cpu_reset_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    latch_d = latch_q;
    case (state_q)
      STATE_FETCH: begin
        latch_d = bus.rom_data;
        state_d = STATE_WRITE;
      end
      STATE_WRITE: begin
        if (idx_q == LAST) begin
          state_d = STATE_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = STATE_FETCH;
        end
      end
      STATE_DONE: ;
      default: state_d = START;
    endcase
    // Reload overrides the transition, but the strobe below still follows the current state.
    if (reload) begin
      state_d = START;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= START;
      idx_q       <= '0;
      latch_q     <= '0;
      done_q      <= 1'b0;
      cpu_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      latch_q     <= latch_d;
      done_q      <= (state_d == STATE_DONE);
      cpu_reset_q <= (state_d == STATE_DONE);
    end
  end

  always_comb begin
    bus.rom_address = idx_q;
    if (state_q == STATE_DONE) begin
      bus.ram_address      = bus.cpu_address;
      bus.ram_data_out     = bus.cpu_data_out;
      bus.ram_write_enable = bus.cpu_write_enable;
    end else begin
      bus.ram_address      = BASE + idx_q;
      bus.ram_data_out     = latch_q;
      bus.ram_write_enable = (state_q == STATE_WRITE);
    end
  end

  assign done       = done_q;
  assign cpu_reset  = cpu_reset_q;
  assign copy_index = idx_q;

endmodule

// File: tb/tb_rom_boot_loader.sv
// Scoreboarded bench: expected RAM writes are queued by the stimulus and popped by monitors.
module tb_rom_boot_loader;

  typedef struct packed {
    logic [9:0]  a;
    logic [15:0] d;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_bc, reload_a;
  logic cpu_reset_a, done_a, cpu_reset_b, done_b, cpu_reset_c, done_c;
  logic [9:0] idx_a, idx_b, idx_c;

  logic [15:0] img [8] = '{16'h8000, 16'h0019, 16'h4001, 16'h8000,
                           16'h0020, 16'h5001, 16'h8001, 16'h0400};
  logic [15:0] mem_a [1024];
  logic [15:0] mem_b [1024];

  wr_t q_a[$], q_b[$], q_c[$];
  int n_vec  = 0;
  int n_fail = 0;
  int wr_cnt_a = 0;

  rom_boot_loader_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) bus_a ();
  rom_boot_loader_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) bus_b ();
  rom_boot_loader_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) bus_c ();

  function automatic logic [15:0] rom_rd(input logic [9:0] a);
    return (a < 10'd8) ? img[a[2:0]] : 16'h0000;
  endfunction

  assign bus_a.rom_data = rom_rd(bus_a.rom_address);
  assign bus_b.rom_data = rom_rd(bus_b.rom_address);
  assign bus_c.rom_data = rom_rd(bus_c.rom_address);

  rom_boot_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .ROM_WORDS(8), .RAM_BASE(0)) dut_a (
    .clk(clk), .reset(rst_a), .reload(reload_a), .bus(bus_a.master),
    .cpu_reset(cpu_reset_a), .done(done_a), .copy_index(idx_a));

  rom_boot_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .ROM_WORDS(8), .RAM_BASE(10'h3FC)) dut_b (
    .clk(clk), .reset(rst_bc), .reload(1'b0), .bus(bus_b.master),
    .cpu_reset(cpu_reset_b), .done(done_b), .copy_index(idx_b));

  rom_boot_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .ROM_WORDS(0), .RAM_BASE(0)) dut_c (
    .clk(clk), .reset(rst_bc), .reload(1'b0), .bus(bus_c.master),
    .cpu_reset(cpu_reset_c), .done(done_c), .copy_index(idx_c));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [9:0] a, input logic [15:0] d);
    n_vec++;
    n_fail++;
    $display("FAIL %s: unexpected write addr=%h data=%h, expected no write", nm, a, d);
  endtask

  always @(posedge clk) begin
    if (bus_a.ram_write_enable) mem_a[bus_a.ram_address] <= bus_a.ram_data_out;
    if (bus_b.ram_write_enable) mem_b[bus_b.ram_address] <= bus_b.ram_data_out;
  end

  always @(negedge clk) begin
    wr_t e;
    if (bus_a.ram_write_enable) begin
      wr_cnt_a++;
      if (q_a.size() == 0) unexpected("wr_a", bus_a.ram_address, bus_a.ram_data_out);
      else begin
        e = q_a.pop_front();
        chk("wr_a", {6'b0, bus_a.ram_address, bus_a.ram_data_out}, {6'b0, e});
      end
    end
    if (bus_b.ram_write_enable) begin
      if (q_b.size() == 0) unexpected("wr_b", bus_b.ram_address, bus_b.ram_data_out);
      else begin
        e = q_b.pop_front();
        chk("wr_b", {6'b0, bus_b.ram_address, bus_b.ram_data_out}, {6'b0, e});
      end
    end
    if (bus_c.ram_write_enable) begin
      if (q_c.size() == 0) unexpected("wr_c", bus_c.ram_address, bus_c.ram_data_out);
      else begin
        e = q_c.pop_front();
        chk("wr_c", {6'b0, bus_c.ram_address, bus_c.ram_data_out}, {6'b0, e});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int first, input int last);
    for (int i = first; i <= last; i++) q_a.push_back('{a: 10'(i), d: img[i]});
  endtask

  task automatic check_done_a(input string nm, input logic exp);
    chk({nm, "_done"}, {31'b0, done_a}, {31'b0, exp});
    chk({nm, "_cpu_reset"}, {31'b0, cpu_reset_a}, {31'b0, exp});
  endtask

  initial begin
    rst_a = 1'b0; rst_bc = 1'b0; reload_a = 1'b0;
    bus_a.cpu_address = 10'h001; bus_a.cpu_data_out = 16'hBEEF; bus_a.cpu_write_enable = 1'b1;
    bus_b.cpu_address = '0; bus_b.cpu_data_out = '0; bus_b.cpu_write_enable = 1'b0;
    bus_c.cpu_address = '0; bus_c.cpu_data_out = '0; bus_c.cpu_write_enable = 1'b0;
    for (int i = 0; i < 1024; i++) begin mem_a[i] = 16'h0; mem_b[i] = 16'h0; end

    // Test 1/2/3a: full copy with the core strobing RAM throughout the copy.
    push_a(0, 7);
    for (int i = 0; i < 8; i++) q_b.push_back('{a: 10'h3FC + 10'(i), d: img[i]});
    step(2);
    check_done_a("rst_a", 1'b0);
    chk("rst_a_idx", {22'b0, idx_a}, 32'd0);
    chk("rst_a_we", {31'b0, bus_a.ram_write_enable}, 32'd0);
    chk("rst_c_done", {31'b0, done_c}, 32'd0);
    rst_a = 1'b1; rst_bc = 1'b1;
    step(1);
    chk("c_done_edge1", {30'b0, done_c, cpu_reset_c}, 32'd3);
    step(14);
    check_done_a("a_edge15", 1'b0);
    bus_a.cpu_write_enable = 1'b0;
    step(1);
    check_done_a("a_edge16", 1'b1);
    chk("b_done_edge16", {31'b0, done_b}, 32'd1);
    chk("a_wr_count", wr_cnt_a, 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("mem_a_img", {16'b0, mem_a[i]}, {16'b0, img[i]});
      chk("mem_b_wrap", {16'b0, mem_b[10'h3FC + 10'(i)]}, {16'b0, img[i]});
    end

    // Test 3b: the core owns RAM after DONE.
    q_a.push_back('{a: 10'h001, d: 16'hBEEF});
    bus_a.cpu_write_enable = 1'b1;
    step(1);
    bus_a.cpu_write_enable = 1'b0;
    bus_a.cpu_address = 10'h155;
    #1;
    chk("cpu_wr_mem", {16'b0, mem_a[1]}, 32'h0000BEEF);
    chk("cpu_addr_pass", {22'b0, bus_a.ram_address}, 32'h155);

    // Test 4: reload during the WRITE of word 2.
    rst_a = 1'b0;
    push_a(0, 2);
    push_a(0, 7);
    step(1);
    rst_a = 1'b1;
    step(5);
    reload_a = 1'b1;
    step(1);
    reload_a = 1'b0;
    chk("reload_idx", {22'b0, idx_a}, 32'd0);
    check_done_a("reload_edge6", 1'b0);
    step(15);
    check_done_a("reload_edge21", 1'b0);
    step(1);
    check_done_a("reload_edge22", 1'b1);

    // Test 5: reset asserted mid-copy for one cycle.
    rst_a = 1'b0;
    push_a(0, 2);
    push_a(0, 7);
    step(1);
    rst_a = 1'b1;
    step(7);
    chk("pre_rst_idx", {22'b0, idx_a}, 32'd3);
    rst_a = 1'b0;
    #1;
    chk("midrst_idx", {22'b0, idx_a}, 32'd0);
    chk("midrst_we", {31'b0, bus_a.ram_write_enable}, 32'd0);
    check_done_a("midrst", 1'b0);
    step(1);
    rst_a = 1'b1;
    step(15);
    check_done_a("rerun_edge15", 1'b0);
    step(1);
    check_done_a("rerun_edge16", 1'b1);

    step(2);
    chk("q_a_empty", q_a.size(), 32'd0);
    chk("q_b_empty", q_b.size(), 32'd0);
    chk("c_still_done", {31'b0, done_c}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
